// File: rtl/cache_valid_array_if.sv
// Request/response bundle between the cache controller and the valid/dirty status array.
// Clock and reset are separate plain ports on the array.
interface cache_valid_array_if #(
  parameter int unsigned INDEX_LENGTH = 4,
  parameter int unsigned NUM_WAYS     = 2
);
  logic [INDEX_LENGTH-1:0] index_i;
  logic                    rd_en_i;
  logic                    we_i;
  logic                    deload_i;
  logic [NUM_WAYS-1:0]     way_sel_i;
  logic                    valid_i;
  logic                    dirty_i;
  logic [NUM_WAYS-1:0]     valid_o;
  logic [NUM_WAYS-1:0]     dirty_o;
  logic                    flush_i;
  logic                    flush_busy_o;
  logic                    flush_done_o;
  logic                    wb_req_o;
  logic [INDEX_LENGTH-1:0] wb_index_o;
  logic [NUM_WAYS-1:0]     wb_way_o;
  logic                    wb_ack_i;

  modport master (
    output index_i, rd_en_i, we_i, deload_i, way_sel_i, valid_i, dirty_i, flush_i, wb_ack_i,
    input  valid_o, dirty_o, flush_busy_o, flush_done_o, wb_req_o, wb_index_o, wb_way_o
  );

  modport slave (
    input  index_i, rd_en_i, we_i, deload_i, way_sel_i, valid_i, dirty_i, flush_i, wb_ack_i,
    output valid_o, dirty_o, flush_busy_o, flush_done_o, wb_req_o, wb_index_o, wb_way_o
  );
endinterface

// File: rtl/cache_valid_array.sv
// Per-way valid/dirty status array with write-first registered reads, masked writes,
// deload, and a flush sequencer that requests write-back of dirty ways line by line.
module cache_valid_array #(
  parameter int unsigned INDEX_LENGTH = 4,
  parameter int unsigned CACHE_LINES  = 16,
  parameter int unsigned NUM_WAYS     = 2
) (
  input logic                clk,
  input logic                rst,
  cache_valid_array_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StScan, StWb, StDone} state_e;

  localparam logic [INDEX_LENGTH-1:0] LastLine = INDEX_LENGTH'(CACHE_LINES - 1);

  logic [NUM_WAYS-1:0]     valid_q [CACHE_LINES];
  logic [NUM_WAYS-1:0]     dirty_q [CACHE_LINES];
  logic [NUM_WAYS-1:0]     rd_valid_q, rd_dirty_q;
  state_e                  state_q;
  logic [INDEX_LENGTH-1:0] ptr_q;
  logic [NUM_WAYS-1:0]     wb_way_q;

  logic                busy;
  logic                in_range;
  logic                user_wr;
  logic                clear_en;
  logic [NUM_WAYS-1:0] flush_mask;
  logic [NUM_WAYS-1:0] line_v_cur, line_d_cur;
  logic [NUM_WAYS-1:0] line_v_nxt, line_d_nxt;

  assign busy       = (state_q != StIdle);
  assign in_range   = (32'(bus.index_i) < CACHE_LINES);
  assign user_wr    = !busy && in_range && (bus.we_i || bus.deload_i) && (|bus.way_sel_i);
  assign line_v_cur = in_range ? valid_q[bus.index_i] : '0;
  assign line_d_cur = in_range ? dirty_q[bus.index_i] : '0;
  assign flush_mask = valid_q[ptr_q] & dirty_q[ptr_q];
  assign clear_en   = ((state_q == StScan) && (flush_mask == '0)) ||
                      ((state_q == StWb) && bus.wb_ack_i);

  // Post-update view of the addressed line; feeds both the array and the read port.
  always_comb begin
    line_v_nxt = line_v_cur;
    line_d_nxt = line_d_cur;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (bus.way_sel_i[w]) begin
        if (bus.deload_i) begin
          line_v_nxt[w] = 1'b0;
          line_d_nxt[w] = 1'b0;
        end else if (bus.we_i) begin
          line_v_nxt[w] = bus.valid_i;
          line_d_nxt[w] = bus.dirty_i & bus.valid_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned l = 0; l < CACHE_LINES; l++) begin
        valid_q[l] <= '0;
        dirty_q[l] <= '0;
      end
    end else begin
      for (int unsigned l = 0; l < CACHE_LINES; l++) begin
        if (clear_en && (ptr_q == INDEX_LENGTH'(l))) begin
          valid_q[l] <= '0;
          dirty_q[l] <= '0;
        end else if (user_wr && (bus.index_i == INDEX_LENGTH'(l))) begin
          valid_q[l] <= line_v_nxt;
          dirty_q[l] <= line_d_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= '0;
      rd_dirty_q <= '0;
    end else if (!busy && bus.rd_en_i) begin
      rd_valid_q <= in_range ? line_v_nxt : '0;
      rd_dirty_q <= in_range ? line_d_nxt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      wb_way_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.flush_i) begin
            state_q <= StScan;
            ptr_q   <= '0;
          end
        end
        StScan: begin
          if (flush_mask != '0) begin
            state_q  <= StWb;
            wb_way_q <= flush_mask;
          end else if (ptr_q == LastLine) begin
            state_q <= StDone;
          end else begin
            ptr_q <= ptr_q + INDEX_LENGTH'(1);
          end
        end
        StWb: begin
          if (bus.wb_ack_i) begin
            wb_way_q <= '0;
            if (ptr_q == LastLine) begin
              state_q <= StDone;
            end else begin
              state_q <= StScan;
              ptr_q   <= ptr_q + INDEX_LENGTH'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          ptr_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.valid_o      = rd_valid_q;
  assign bus.dirty_o      = rd_dirty_q;
  assign bus.flush_busy_o = busy;
  assign bus.flush_done_o = (state_q == StDone);
  assign bus.wb_req_o     = (state_q == StWb);
  assign bus.wb_index_o   = (state_q == StWb) ? ptr_q : '0;
  assign bus.wb_way_o     = wb_way_q;

endmodule

// File: tb/tb_cache_valid_array.sv
// Directed and randomized checks of cache_valid_array against a line/way array model,
// including flush timing, write-back handshakes and reset during write-back.
module tb_cache_valid_array;
  localparam int IL    = 4;
  localparam int LINES = 16;
  localparam int NW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_valid_array_if #(.INDEX_LENGTH(IL), .NUM_WAYS(NW)) bus ();

  cache_valid_array #(
    .INDEX_LENGTH(IL),
    .CACHE_LINES (LINES),
    .NUM_WAYS    (NW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;
  bit [NW-1:0] mv [LINES];
  bit [NW-1:0] md [LINES];
  bit [NW-1:0] ev, ed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.index_i   = '0;
    bus.rd_en_i   = 1'b0;
    bus.we_i      = 1'b0;
    bus.deload_i  = 1'b0;
    bus.way_sel_i = '0;
    bus.valid_i   = 1'b0;
    bus.dirty_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.wb_ack_i  = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int l = 0; l < LINES; l++) begin
      mv[l] = '0;
      md[l] = '0;
    end
    ev = '0;
    ed = '0;
  endtask

  // One idle-time access cycle; the model applies the same operation by the stated rules.
  task automatic op(input int idx, input bit rd, input bit we, input bit dl,
                    input bit [NW-1:0] sel, input bit v, input bit d);
    bus.index_i   = idx[IL-1:0];
    bus.rd_en_i   = rd;
    bus.we_i      = we;
    bus.deload_i  = dl;
    bus.way_sel_i = sel;
    bus.valid_i   = v;
    bus.dirty_i   = d;
    step();
    clear_inputs();
    if (idx < LINES) begin
      for (int w = 0; w < NW; w++) begin
        if (sel[w]) begin
          if (dl) begin
            mv[idx][w] = 1'b0;
            md[idx][w] = 1'b0;
          end else if (we) begin
            mv[idx][w] = v;
            md[idx][w] = d & v;
          end
        end
      end
    end
    if (rd) begin
      ev = (idx < LINES) ? mv[idx] : '0;
      ed = (idx < LINES) ? md[idx] : '0;
    end
  endtask

  initial begin
    int cyc, busy_cnt, done_at, wb_seen;
    int exp_idx [2];
    int exp_way [2];
    clear_inputs();

    // Reset state
    #12;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_dirty", bus.dirty_o, 0);
    chk("rst_busy", bus.flush_busy_o, 0);
    chk("rst_done", bus.flush_done_o, 0);
    chk("rst_wbreq", bus.wb_req_o, 0);
    chk("rst_wbway", bus.wb_way_o, 0);
    reset_dut();

    op(3, 1, 0, 0, 2'b00, 0, 0);
    chk("rd3_valid", bus.valid_o, 2'b00);
    chk("rd3_dirty", bus.dirty_o, 2'b00);

    op(5, 0, 1, 0, 2'b10, 1, 1);
    op(5, 1, 0, 0, 2'b00, 0, 0);
    chk("wr5_valid", bus.valid_o, 2'b10);
    chk("wr5_dirty", bus.dirty_o, 2'b10);
    op(5, 0, 1, 0, 2'b10, 0, 1);
    op(5, 1, 0, 0, 2'b00, 0, 0);
    chk("wr5b_valid", bus.valid_o, 2'b00);
    chk("wr5b_dirty", bus.dirty_o, 2'b00);

    op(2, 0, 1, 0, 2'b01, 1, 1);
    op(2, 0, 1, 1, 2'b01, 1, 1);
    op(2, 1, 0, 0, 2'b00, 0, 0);
    chk("deload2_valid", bus.valid_o, 2'b00);
    chk("deload2_dirty", bus.dirty_o, 2'b00);

    op(7, 1, 1, 0, 2'b11, 1, 0);
    chk("rw7_valid", bus.valid_o, 2'b11);
    chk("rw7_dirty", bus.dirty_o, 2'b00);
    op(7, 1, 1, 0, 2'b00, 0, 0);
    chk("sel0_valid", bus.valid_o, 2'b11);
    op(3, 0, 0, 0, 2'b00, 0, 0);
    chk("hold_valid", bus.valid_o, 2'b11);

    // Randomized idle-time traffic against the model
    reset_dut();
    for (int i = 0; i < 250; i++) begin
      op($urandom_range(0, LINES - 1), 1'($urandom), 1'($urandom_range(0, 2) != 0),
         1'($urandom_range(0, 3) == 0), NW'($urandom), 1'($urandom), 1'($urandom));
      chk("rand_valid", bus.valid_o, ev);
      chk("rand_dirty", bus.dirty_o, ed);
    end

    // Flush with only clean lines
    reset_dut();
    op(3, 0, 1, 0, 2'b11, 1, 0);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    cyc = 0; busy_cnt = 0; done_at = 0; wb_seen = 0;
    while (bus.flush_busy_o && cyc < 100) begin
      cyc++;
      busy_cnt++;
      if (bus.flush_done_o) done_at = cyc;
      if (bus.wb_req_o) wb_seen = 1;
      step();
    end
    chk("clean_busy_cycles", busy_cnt, 17);
    chk("clean_done_cycle", done_at, 17);
    chk("clean_no_wbreq", wb_seen, 0);
    op(3, 1, 0, 0, 2'b00, 0, 0);
    chk("clean_cleared3", bus.valid_o, 2'b00);

    // Flush with dirty lines 4 and 9, ack delayed three cycles
    reset_dut();
    op(4, 0, 1, 0, 2'b10, 1, 1);
    op(9, 0, 1, 0, 2'b11, 1, 1);
    op(6, 0, 1, 0, 2'b01, 1, 0);
    op(9, 1, 0, 0, 2'b00, 0, 0);
    chk("pre_valid9", bus.valid_o, 2'b11);
    chk("pre_dirty9", bus.dirty_o, 2'b11);
    bus.wb_ack_i = 1'b1;
    bus.flush_i  = 1'b1;
    step();
    bus.flush_i  = 1'b0;
    bus.wb_ack_i = 1'b0;
    exp_idx[0] = 4; exp_way[0] = 2'b10;
    exp_idx[1] = 9; exp_way[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      while (!bus.wb_req_o && cyc < 50) begin
        cyc++;
        step();
      end
      chk("wb_req_seen", bus.wb_req_o, 1);
      chk("wb_index", bus.wb_index_o, exp_idx[k]);
      chk("wb_way", bus.wb_way_o, exp_way[k]);
      for (int h = 0; h < 3; h++) begin
        if (k == 0 && h == 0) begin
          bus.index_i = 2; bus.we_i = 1'b1; bus.rd_en_i = 1'b1;
          bus.way_sel_i = 2'b11; bus.valid_i = 1'b1; bus.dirty_i = 1'b1; bus.flush_i = 1'b1;
        end
        step();
        clear_inputs();
        chk("wb_req_held", bus.wb_req_o, 1);
        chk("wb_index_held", bus.wb_index_o, exp_idx[k]);
        chk("wb_way_held", bus.wb_way_o, exp_way[k]);
        chk("busy_rd_hold", bus.valid_o, 2'b11);
      end
      bus.wb_ack_i = 1'b1;
      step();
      bus.wb_ack_i = 1'b0;
      chk("wb_req_drop", bus.wb_req_o, 0);
    end
    cyc = 0;
    while (!bus.flush_done_o && cyc < 50) begin
      cyc++;
      step();
    end
    chk("dirty_done", bus.flush_done_o, 1);
    step();
    chk("dirty_idle", bus.flush_busy_o, 0);
    op(4, 1, 0, 0, 2'b00, 0, 0);
    chk("cleared4", {bus.valid_o, bus.dirty_o}, 0);
    op(9, 1, 0, 0, 2'b00, 0, 0);
    chk("cleared9", {bus.valid_o, bus.dirty_o}, 0);
    op(6, 1, 0, 0, 2'b00, 0, 0);
    chk("cleared6", {bus.valid_o, bus.dirty_o}, 0);
    op(2, 1, 0, 0, 2'b00, 0, 0);
    chk("busy_write_ignored2", {bus.valid_o, bus.dirty_o}, 0);

    // Reset while waiting for write-back ack
    reset_dut();
    op(9, 0, 1, 0, 2'b01, 1, 1);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    cyc = 0;
    while (!bus.wb_req_o && cyc < 50) begin
      cyc++;
      step();
    end
    chk("rstwb_req_seen", bus.wb_req_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstwb_req_low", bus.wb_req_o, 0);
    chk("rstwb_busy_low", bus.flush_busy_o, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    op(9, 1, 0, 0, 2'b00, 0, 0);
    chk("rstwb_cleared9", {bus.valid_o, bus.dirty_o}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
